// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the 3-port AXI3 AW arbiter.
package axi_arb_pkg;

    localparam int NUM_PORTS = 3;

    typedef logic [1:0] port_idx_t;

    typedef enum logic [1:0] {
        ARB_FIXED = 2'd0,
        ARB_RR    = 2'd1,
        ARB_WRR   = 2'd2,
        ARB_RSVD  = 2'd3
    } arb_mode_e;

    localparam logic [16:0] CNT_MAX = 17'h1FFFF;

    // Port index after p, wrapping modulo NUM_PORTS.
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == port_idx_t'(NUM_PORTS - 1)) ? port_idx_t'(0) : p + port_idx_t'(1);
    endfunction

    // First requesting port at or after 'start', searching cyclically.
    // A start of 0 gives plain fixed priority 0 > 1 > 2.
    function automatic port_idx_t rr_pick(input logic [NUM_PORTS-1:0] req,
                                          input port_idx_t start);
        port_idx_t idx;
        port_idx_t pick;
        logic      found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = next_port(idx);
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_sel_fifo.sv
// Write-order FIFO: remembers which port each accepted AW came from so the
// W channel can be routed in address order.
module arb_sel_fifo
    import axi_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  port_idx_t push_data,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output port_idx_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    port_idx_t     mem [DEPTH];
    logic          do_push, do_pop;

    // Push is refused when full even if a pop happens the same cycle; pop of
    // an empty FIFO is ignored.
    always_comb begin
        full    = (count == (AW+1)'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = empty ? port_idx_t'(0) : mem[rd_ptr];
    end

    // Storage and pointers; power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi3_aw_arbiter.sv
// Three-port AXI3 AW arbiter: fixed / round-robin / weighted round-robin
// selection into a single registered downstream AW, plus write-order tracking.
module axi3_aw_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 4,
    parameter int WSEL_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                arb_en,
    input  logic [1:0]                          arb_mode,
    input  logic [NUM_PORTS-1:0][15:0]          weight,
    input  logic [NUM_PORTS-1:0]                s_awvalid,
    output logic [NUM_PORTS-1:0]                s_awready,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    s_awaddr,
    input  logic [NUM_PORTS-1:0][ID_W-1:0]      s_awid,
    input  logic [NUM_PORTS-1:0][7:0]           s_awlen,
    output logic                                m_awvalid,
    input  logic                                m_awready,
    output logic [ADDR_W-1:0]                   m_awaddr,
    output logic [ID_W-1:0]                     m_awid,
    output logic [7:0]                          m_awlen,
    output logic [1:0]                          wsel,
    output logic                                wsel_valid,
    input  logic                                wsel_pop
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [7:0]        len;
    } aw_pay_t;

    arb_mode_e            mode, mode_q;
    logic                 live;        // low for the first cycle out of reset
    logic                 oreg_vld;
    aw_pay_t              oreg;
    port_idx_t            ptr;         // rotating highest-priority port
    port_idx_t            holder;      // last granted port
    logic [16:0]          cnt;         // consecutive grants to holder
    logic [16:0]          c_eff;
    logic [NUM_PORTS-1:0] eligible;
    logic                 rr_en, accept_ok, grant;
    port_idx_t            win;
    logic                 fifo_full, fifo_empty;

    // Winner selection and per-port ready; ready only goes to the winner.
    always_comb begin
        mode      = arb_mode_e'(arb_mode);
        eligible  = arb_en ? s_awvalid : {{(NUM_PORTS-1){1'b0}}, s_awvalid[0]};
        c_eff     = (!arb_en || mode != mode_q) ? 17'd0 : cnt;
        rr_en     = arb_en && (mode == ARB_RR || mode == ARB_WRR);
        accept_ok = live && (!oreg_vld || m_awready) && !fifo_full;
        grant     = accept_ok && (|eligible);
        if (!rr_en)
            win = rr_pick(eligible, port_idx_t'(0));
        else if (mode == ARB_WRR && c_eff != 17'd0 && eligible[holder] &&
                 c_eff <= {1'b0, weight[holder]})
            win = holder;
        else
            win = rr_pick(eligible, ptr);
        for (int i = 0; i < NUM_PORTS; i++)
            s_awready[i] = grant && (win == port_idx_t'(i));
    end

    // Arbitration state: pointer, run holder/counter, last mode seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live   <= 1'b0;
            ptr    <= '0;
            holder <= '0;
            cnt    <= '0;
            mode_q <= ARB_FIXED;
        end else begin
            live   <= 1'b1;
            mode_q <= mode;
            if (!arb_en) begin
                cnt <= '0;
            end else if (grant) begin
                holder <= win;
                if (win == holder && c_eff != 17'd0)
                    cnt <= (c_eff == CNT_MAX) ? c_eff : c_eff + 17'd1;
                else
                    cnt <= 17'd1;
                if (rr_en) ptr <= next_port(win);
            end else begin
                cnt <= c_eff;
            end
        end
    end

    // Output register: loads on accept, empties on downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_vld <= 1'b0;
            oreg     <= '0;
        end else if (grant) begin
            oreg_vld <= 1'b1;
            oreg     <= '{addr: s_awaddr[win], id: s_awid[win], len: s_awlen[win]};
        end else if (m_awready) begin
            oreg_vld <= 1'b0;
        end
    end

    assign m_awvalid  = oreg_vld;
    assign m_awaddr   = oreg.addr;
    assign m_awid     = oreg.id;
    assign m_awlen    = oreg.len;
    assign wsel_valid = !fifo_empty;

    arb_sel_fifo #(.DEPTH(WSEL_DEPTH)) u_sel_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (win),
        .pop       (wsel_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (wsel)
    );

endmodule

// File: tb/tb_axi3_aw_arbiter.sv
// Directed bench for axi3_aw_arbiter with payload / write-order scoreboards.
module tb_axi3_aw_arbiter;
    import axi_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 4;

    logic                             clk, rst_n, arb_en;
    logic [1:0]                       arb_mode;
    logic [NUM_PORTS-1:0][15:0]       weight;
    logic [NUM_PORTS-1:0]             s_awvalid, s_awready;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] s_awaddr;
    logic [NUM_PORTS-1:0][ID_W-1:0]   s_awid;
    logic [NUM_PORTS-1:0][7:0]        s_awlen;
    logic                             m_awvalid, m_awready;
    logic [ADDR_W-1:0]                m_awaddr;
    logic [ID_W-1:0]                  m_awid;
    logic [7:0]                       m_awlen;
    logic [1:0]                       wsel;
    logic                             wsel_valid, wsel_pop;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [7:0]        len;
    } aw_t;

    aw_t        aw_q[$];
    logic [1:0] ws_q[$];
    int         seq[$];
    int         n_chk = 0;
    int         n_pass = 0;

    axi3_aw_arbiter #(.ADDR_W(ADDR_W), .ID_W(ID_W), .WSEL_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .arb_mode(arb_mode), .weight(weight),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awid(s_awid), .s_awlen(s_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
        .wsel(wsel), .wsel_valid(wsel_valid), .wsel_pop(wsel_pop)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic aw_t pay(input int p);
        aw_t r;
        r.addr = 32'hA000_0000 + 32'(p) * 32'h100;
        r.id   = ID_W'(p + 1);
        r.len  = 8'(8'h10 + p);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Compare any downstream handshake / W-select pop against the scoreboards.
    task automatic monitor(input string tag);
        aw_t        e;
        logic [1:0] w;
        if (m_awvalid && m_awready) begin
            if (aw_q.size() == 0) chk({tag, " aw-extra"}, 64'(aw_q.size()), 64'd1);
            else begin
                e = aw_q.pop_front();
                chk({tag, " aw"}, 64'({m_awaddr, m_awid, m_awlen}), 64'(e));
            end
        end
        if (wsel_valid && wsel_pop) begin
            if (ws_q.size() == 0) chk({tag, " wsel-extra"}, 64'(ws_q.size()), 64'd1);
            else begin
                w = ws_q.pop_front();
                chk({tag, " wsel"}, 64'(wsel), 64'(w));
            end
        end
    endtask

    // One cycle: settle, check outputs and ready, record the expected accept.
    task automatic cyc(input string tag, input logic [2:0] exp_rdy);
        #1;
        monitor(tag);
        chk({tag, " rdy"}, 64'(s_awready), 64'(exp_rdy));
        for (int p = 0; p < NUM_PORTS; p++)
            if (exp_rdy[p]) begin
                aw_q.push_back(pay(p));
                ws_q.push_back(2'(p));
            end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        s_awvalid = '0;
        m_awready = 1'b1;
        wsel_pop  = 1'b1;
        for (int i = 0; i < 12 && (aw_q.size() + ws_q.size()) != 0; i++)
            cyc({tag, " drain"}, 3'b000);
        chk({tag, " drained"}, 64'(aw_q.size() + ws_q.size()), 64'd0);
    endtask

    // All ports valid, free-flowing downstream; grants must follow seq.
    task automatic run_seq(input string tag, input logic en, input logic [1:0] mode);
        arb_en    = en;
        arb_mode  = mode;
        s_awvalid = 3'b111;
        m_awready = 1'b1;
        wsel_pop  = 1'b1;
        foreach (seq[k]) cyc($sformatf("%s g%0d", tag, k), 3'(1 << seq[k]));
        drain(tag);
    endtask

    initial begin
        aw_t t;
        clk = 0; rst_n = 0; arb_en = 1; arb_mode = 0; weight = '0;
        s_awvalid = 3'b111; m_awready = 0; wsel_pop = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            t = pay(p);
            s_awaddr[p] = t.addr; s_awid[p] = t.id; s_awlen[p] = t.len;
        end

        // Reset state with requests pending
        #12;
        chk("rst m_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst wsel_valid", 64'(wsel_valid), 64'd0);
        chk("rst s_awready", 64'(s_awready), 64'd0);
        chk("rst m_awaddr", 64'(m_awaddr), 64'd0);
        chk("rst wsel", 64'(wsel), 64'd0);
        s_awvalid = '0;
        rst_n = 1;
        @(posedge clk); #1;

        seq = '{0, 0, 0, 0, 0, 0};
        run_seq("fixed", 1'b1, 2'd0);

        seq = '{0, 1, 2, 0, 1, 2};
        run_seq("rr", 1'b1, 2'd1);

        weight[0] = 16'd2; weight[1] = 16'd1; weight[2] = 16'd0;
        seq = '{0, 0, 0, 1, 1, 2, 0, 0, 0};
        run_seq("wrr", 1'b1, 2'd2);

        seq = '{0, 0, 0, 0};
        run_seq("arb_off", 1'b0, 2'd1);

        // Downstream stall holds OREG, then FIFO-full back-pressure
        arb_en = 1; arb_mode = 0;
        s_awvalid = 3'b010; m_awready = 0; wsel_pop = 0;
        cyc("stall acc", 3'b010);
        cyc("stall hold", 3'b000);
        chk("stall m_awvalid", 64'(m_awvalid), 64'd1);
        chk("stall payload", 64'({m_awaddr, m_awid, m_awlen}), 64'(pay(1)));
        cyc("stall hold2", 3'b000);
        chk("stall payload2", 64'({m_awaddr, m_awid, m_awlen}), 64'(pay(1)));
        m_awready = 1;
        cyc("fill1", 3'b010);
        cyc("fill2", 3'b010);
        cyc("fill3", 3'b010);
        cyc("full", 3'b000);
        cyc("full2", 3'b000);
        wsel_pop = 1;
        cyc("full pop", 3'b000);
        wsel_pop = 0;
        cyc("after pop", 3'b010);
        drain("stall");

        // Reset mid-handshake with OREG busy and FIFO holding three
        arb_mode = 1; s_awvalid = 3'b010; m_awready = 1; wsel_pop = 0;
        cyc("pre1", 3'b010);
        cyc("pre2", 3'b010);
        cyc("pre3", 3'b010);
        s_awvalid = '0; m_awready = 0;
        cyc("pre hold", 3'b000);
        chk("pre m_awvalid", 64'(m_awvalid), 64'd1);
        chk("pre wsel_valid", 64'(wsel_valid), 64'd1);
        #2;
        s_awvalid = 3'b111;
        rst_n = 0;
        #1;
        chk("mid-rst m_awvalid", 64'(m_awvalid), 64'd0);
        chk("mid-rst wsel_valid", 64'(wsel_valid), 64'd0);
        chk("mid-rst wsel", 64'(wsel), 64'd0);
        chk("mid-rst s_awready", 64'(s_awready), 64'd0);
        aw_q.delete();
        ws_q.delete();
        @(posedge clk); #1;
        rst_n = 1; m_awready = 1; wsel_pop = 1;
        @(posedge clk); #1;
        cyc("post-rst g0", 3'b001);
        cyc("post-rst g1", 3'b010);
        drain("post-rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi3_aw_arbiter.md
AXI3_AW_ARBITER -- requirements
Module: axi3_aw_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, AW address width.
REQ-002 Parameter ID_W, default 4, AW ID width.
REQ-003 Parameter WSEL_DEPTH, default 4, write-order FIFO depth (power of 2, >=2).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 arb_en  in  1  arbitration enable; 0 = only port 0 serviced.
REQ-007 arb_mode  in  2  0 fixed priority, 1 round robin, 2 weighted round robin, 3 reserved.
REQ-008 weight  in  3x16  per-port weight W_i, port i in bits [16i+15:16i].
REQ-009 s_awvalid / s_awready  in / out  3 / 3  per-port AW handshake, bit i = port i.
REQ-010 s_awaddr / s_awid / s_awlen  in  3xADDR_W / 3xID_W / 3x8  per-port AW payload, port i in slice i.
REQ-011 m_awvalid / m_awready  out / in  1 / 1  downstream AW handshake.
REQ-012 m_awaddr / m_awid / m_awlen  out  ADDR_W / ID_W / 8  downstream AW payload.
REQ-013 wsel / wsel_valid / wsel_pop  out / out / in  2 / 1 / 1  port index of oldest accepted AW, for W-channel routing.

Function
REQ-014 One output register (OREG) holds the downstream AW; m_aw* driven only from OREG, no combinational path from s_aw* to m_aw*.
REQ-015 Accept allowed in a cycle when (OREG empty or m_awready) and write-order FIFO not full; full blocks acceptance even with a simultaneous wsel_pop.
REQ-016 When accept is allowed and at least one eligible port is valid, exactly one winner is chosen; s_awready of the winner only is 1 in that cycle, all others 0.
REQ-017 On an accept, the winner's payload loads OREG (m_awvalid=1 next cycle) and the winner's index is pushed into the FIFO; AW latency = 1 cycle; throughput = 1 AW/cycle.
REQ-018 m_awvalid stays 1 with stable payload until m_awready; OREG empties on m_awready unless reloaded the same cycle.
REQ-019 arb_en=0: eligible set = port 0 only; ports 1 and 2 never see s_awready=1.
REQ-020 Mode 0: priority 0 > 1 > 2, no state.
REQ-021 Mode 1: rotating pointer; after grant to port i, highest priority becomes (i+1) mod 3; a port is never granted twice consecutively while another port is valid.
REQ-022 Mode 2: per-port run counter C (17 bit) counts consecutive grants to the current holder; holder keeps priority while C <= W_holder; after W_holder+1 consecutive grants with another port valid, priority rotates as in mode 1; W=0 equals mode 1.
REQ-023 Mode 3 behaves as mode 0.
REQ-024 C resets to 0 on grant to a different port, on arb_en=0, and on any arb_mode change; counter saturates at 17'h1FFFF.
REQ-025 Mode/weight/arb_en changes take effect at the next accept decision; an AW already in OREG is never dropped.
REQ-026 FIFO: wsel_valid = not empty; wsel = head; wsel_pop with wsel_valid=0 is ignored; simultaneous push and pop when not full keeps count unchanged; pointers wrap modulo WSEL_DEPTH.

Reset
REQ-027 Asserting rst_n low at any time (including mid-handshake) clears OREG (m_awvalid=0), FIFO (wsel_valid=0, wsel=0), run counter, and rotating pointer (to port 0) asynchronously.
REQ-028 During reset s_awready=0 on all ports; m_awaddr/m_awid/m_awlen reset to 0.

Structure
REQ-029 Package axi_arb_pkg holds arb_mode enum (ARB_FIXED, ARB_RR, ARB_WRR, ARB_RSVD), port-index typedef (2 bit) and NUM_PORTS=3.
REQ-030 Write-order FIFO is sub-module arb_sel_fifo (parameter DEPTH, data 2 bit); arbitration and OREG stay in the top.

Verification
REQ-031 arb_en=1, mode 0, all three valid continuously, m_awready=1 -> six accepts all to port 0; ports 1, 2 starve.
REQ-032 arb_en=1, mode 1, all valid, m_awready=1 -> grant order 0,1,2,0,1,2; wsel pops return same order.
REQ-033 arb_en=1, mode 2, weight={W2=0,W1=1,W0=2}, all valid -> grants 0,0,0,1,1,2,0,0,0.
REQ-034 arb_en=0, all valid -> only port 0 accepted; s_awready[2:1] never 1.
REQ-035 m_awready=0, wsel_pop=0, port 1 valid -> one accept into OREG, then accepts stop; m_awvalid held with stable payload; with m_awready=1, WSEL_DEPTH=4 and no pops, exactly 4 accepts then stall until a pop.
REQ-036 Assert rst_n low while m_awvalid=1 and FIFO holds 3 -> m_awvalid=0, wsel_valid=0 immediately; first grant after release in mode 1 goes to port 0.
